// File: rtl/exc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exc_sequencer
//  Purpose  : Exception/interrupt commit controller between the MEM stage and
//             CP0. It samples the MEM exception flags, ERET and the pending
//             interrupt in IDLE. It picks one cause by fixed priority and
//             presents the code, EPC and BadVAddr to CP0 for exactly one
//             cycle. It then issues a held fetch redirect to the CP0-supplied
//             target and keeps the pipeline flushed until the front end has
//             restarted.
//  Ports    : cpu_clk_50M / cpu_rst     clock, async active-high reset
//             mem_*_i                   MEM-stage instruction info
//             status_i / cause_i        CP0 Status / Cause
//             cp0_excaddr_i             target from CP0 (comb. on exccode_o)
//             redirect_ready_i          fetch accepts redirect
//             exccode_o, epc_pc_o,
//             in_delay_o, badvaddr_o    commit information to CP0
//             flush_o                   flush IF..MEM
//             redirect_valid_o/addr_o   fetch redirect request
//             busy_o                    sequencer not idle
//  Revision : 1.0  initial release
// ============================================================================
module exc_sequencer #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_i,
    input  logic [6:0]  mem_exc_i,
    input  logic        mem_eret_i,
    input  logic [31:0] mem_daddr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] cp0_excaddr_i,
    input  logic        redirect_ready_i,
    output logic [4:0]  exccode_o,
    output logic [31:0] epc_pc_o,
    output logic        in_delay_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_addr_o,
    output logic        busy_o
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_drain_load = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_commit   = 2'd1;
    localparam logic [1:0] c_st_redirect = 2'd2;
    localparam logic [1:0] c_st_drain    = 2'd3;

    localparam logic [4:0] c_exc_int  = 5'h00;
    localparam logic [4:0] c_exc_adel = 5'h04;
    localparam logic [4:0] c_exc_ades = 5'h05;
    localparam logic [4:0] c_exc_sys  = 5'h08;
    localparam logic [4:0] c_exc_bp   = 5'h09;
    localparam logic [4:0] c_exc_ri   = 5'h0a;
    localparam logic [4:0] c_exc_ov   = 5'h0c;
    localparam logic [4:0] c_exc_none = 5'h10;
    localparam logic [4:0] c_exc_eret = 5'h11;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       exccode_q, exccode_d;
    logic [31:0]      epc_q, epc_d;
    logic             in_delay_q, in_delay_d;
    logic [31:0]      badvaddr_q, badvaddr_d;
    logic             flush_q, flush_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_addr_q, redirect_addr_d;

    logic             w_int_p;
    logic             w_trigger;
    logic [4:0]       w_code;
    logic             w_bad_pc;
    logic             w_bad_data;
    logic             w_unused;

    // Only the IE/EXL bits and the interrupt mask/pending fields matter here.
    assign w_unused = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    assign w_int_p   = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));
    assign w_trigger = mem_valid_i & (w_int_p | (|mem_exc_i) | mem_eret_i);

    // Fixed-priority cause selection; BadVAddr source follows the winner.
    always_comb begin : p_priority
        w_code     = c_exc_none;
        w_bad_pc   = 1'b0;
        w_bad_data = 1'b0;
        if (w_int_p) begin
            w_code = c_exc_int;
        end else if (mem_exc_i[0]) begin
            w_code   = c_exc_adel;
            w_bad_pc = 1'b1;
        end else if (mem_exc_i[1]) begin
            w_code = c_exc_ri;
        end else if (mem_exc_i[2]) begin
            w_code = c_exc_ov;
        end else if (mem_exc_i[3]) begin
            w_code = c_exc_sys;
        end else if (mem_exc_i[4]) begin
            w_code = c_exc_bp;
        end else if (mem_exc_i[5]) begin
            w_code     = c_exc_adel;
            w_bad_data = 1'b1;
        end else if (mem_exc_i[6]) begin
            w_code     = c_exc_ades;
            w_bad_data = 1'b1;
        end else if (mem_eret_i) begin
            w_code = c_exc_eret;
        end
    end

    // State register
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin : p_next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_st_idle: begin
                if (w_trigger) begin
                    state_d = c_st_commit;
                end
            end
            c_st_commit: begin
                state_d = c_st_redirect;
            end
            c_st_redirect: begin
                if (redirect_valid_q && redirect_ready_i) begin
                    state_d = c_st_drain;
                    cnt_d   = c_drain_load;
                end
            end
            c_st_drain: begin
                cnt_d = cnt_q - c_cnt_one;
                if (cnt_q == c_cnt_one) begin
                    state_d = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: computes the next value of every registered output so
    // that nothing reaches the ports combinationally from the inputs.
    always_comb begin : p_outputs
        exccode_d        = c_exc_none;
        epc_d            = epc_q;
        in_delay_d       = in_delay_q;
        badvaddr_d       = badvaddr_q;
        redirect_addr_d  = redirect_addr_q;
        flush_d          = (state_d != c_st_idle);
        redirect_valid_d = (state_d == c_st_redirect);

        if ((state_q == c_st_idle) && w_trigger) begin
            exccode_d  = w_code;
            epc_d      = mem_pc_i;
            in_delay_d = mem_in_delay_i;
            if (w_bad_pc) begin
                badvaddr_d = mem_pc_i;
            end else if (w_bad_data) begin
                badvaddr_d = mem_daddr_i;
            end
        end

        // CP0 resolves the target from exccode_o during COMMIT; freeze it
        // here so it stays constant for the whole redirect wait.
        if (state_q == c_st_commit) begin
            redirect_addr_d = cp0_excaddr_i;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            exccode_q        <= c_exc_none;
            epc_q            <= '0;
            in_delay_q       <= 1'b0;
            badvaddr_q       <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
        end else begin
            exccode_q        <= exccode_d;
            epc_q            <= epc_d;
            in_delay_q       <= in_delay_d;
            badvaddr_q       <= badvaddr_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_addr_q  <= redirect_addr_d;
        end
    end

    assign exccode_o        = exccode_q;
    assign epc_pc_o         = epc_q;
    assign in_delay_o       = in_delay_q;
    assign badvaddr_o       = badvaddr_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_addr_o  = redirect_addr_q;
    assign busy_o           = (state_q != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_exc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exc_sequencer
//  Purpose  : Directed self-checking bench for exc_sequencer (DRAIN_CYCLES=2)
//  Revision : 1.0  initial release
// ============================================================================
module tb_exc_sequencer;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delay_i;
    logic [6:0]  mem_exc_i;
    logic        mem_eret_i;
    logic [31:0] mem_daddr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] cp0_excaddr_i;
    logic        redirect_ready_i;
    logic [4:0]  exccode_o;
    logic [31:0] epc_pc_o;
    logic        in_delay_o;
    logic [31:0] badvaddr_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_addr_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    exc_sequencer #(.DRAIN_CYCLES(2)) dut (
        .cpu_clk_50M      (cpu_clk_50M),
        .cpu_rst          (cpu_rst),
        .mem_valid_i      (mem_valid_i),
        .mem_pc_i         (mem_pc_i),
        .mem_in_delay_i   (mem_in_delay_i),
        .mem_exc_i        (mem_exc_i),
        .mem_eret_i       (mem_eret_i),
        .mem_daddr_i      (mem_daddr_i),
        .status_i         (status_i),
        .cause_i          (cause_i),
        .cp0_excaddr_i    (cp0_excaddr_i),
        .redirect_ready_i (redirect_ready_i),
        .exccode_o        (exccode_o),
        .epc_pc_o         (epc_pc_o),
        .in_delay_o       (in_delay_o),
        .badvaddr_o       (badvaddr_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_addr_o  (redirect_addr_o),
        .busy_o           (busy_o)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    task automatic step();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic clear_inputs();
        mem_valid_i      = 1'b0;
        mem_pc_i         = 32'h0;
        mem_in_delay_i   = 1'b0;
        mem_exc_i        = 7'b0;
        mem_eret_i       = 1'b0;
        mem_daddr_i      = 32'h0;
        status_i         = 32'h0;
        cause_i          = 32'h0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, busy_o, n);
        end
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        clear_inputs();
        redirect_ready_i = 1'b1;
        cp0_excaddr_i    = 32'hbfc00380;
        step();
        checks++;
        if (exccode_o !== 5'h10) begin
            errors++;
            $display("FAIL reset_exccode: got %h want 10", exccode_o);
        end
        checks++;
        if ({epc_pc_o, in_delay_o, badvaddr_o, flush_o, redirect_valid_o, redirect_addr_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: epc=%h dly=%b bad=%h fl=%b rv=%b ra=%h busy=%b want all 0",
                     epc_pc_o, in_delay_o, badvaddr_o, flush_o, redirect_valid_o, redirect_addr_o, busy_o);
        end
        cpu_rst = 1'b0;
        step();
        // Pending interrupt and RI flag but no valid instruction: no trigger.
        status_i    = 32'h0000ff01;
        cause_i     = 32'h00000400;
        mem_exc_i   = 7'b0000010;
        mem_valid_i = 1'b0;
        step();
        step();
        checks++;
        if (busy_o !== 1'b0 || exccode_o !== 5'h10) begin
            errors++;
            $display("FAIL novalid_ignored: busy=%b code=%h want busy=0 code=10", busy_o, exccode_o);
        end
        clear_inputs();
    endtask

    task automatic test_ri();
        int nflush;
        mem_pc_i         = 32'hbfc00100;
        mem_in_delay_i   = 1'b0;
        mem_exc_i        = 7'b0000010;
        mem_valid_i      = 1'b1;
        redirect_ready_i = 1'b1;
        cp0_excaddr_i    = 32'hbfc00380;
        step();
        checks++;
        if (exccode_o !== 5'h0a || epc_pc_o !== 32'hbfc00100 || in_delay_o !== 1'b0) begin
            errors++;
            $display("FAIL ri_commit: code=%h epc=%h dly=%b want 0a bfc00100 0", exccode_o, epc_pc_o, in_delay_o);
        end
        checks++;
        if (flush_o !== 1'b1 || redirect_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL ri_commit_ctl: fl=%b rv=%b busy=%b want 1 0 1", flush_o, redirect_valid_o, busy_o);
        end
        nflush = flush_o ? 1 : 0;
        clear_inputs();
        step();
        checks++;
        if (exccode_o !== 5'h10 || redirect_valid_o !== 1'b1 || redirect_addr_o !== 32'hbfc00380) begin
            errors++;
            $display("FAIL ri_redirect: code=%h rv=%b ra=%h want 10 1 bfc00380", exccode_o, redirect_valid_o, redirect_addr_o);
        end
        if (flush_o) nflush++;
        for (int k = 0; k < 6; k++) begin
            step();
            if (flush_o) nflush++;
        end
        checks++;
        if (nflush !== 4) begin
            errors++;
            $display("FAIL ri_flush_len: got %0d cycles want 4", nflush);
        end
        wait_idle("ri");
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_seq [6];
        exp_seq = '{5'h0a, 5'h10, 5'h10, 5'h10, 5'h10, 5'h0a};
        mem_pc_i         = 32'hbfc00140;
        mem_exc_i        = 7'b0000010;
        mem_valid_i      = 1'b1;
        redirect_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (exccode_o !== exp_seq[k]) begin
                errors++;
                $display("FAIL b2b_code_t%0d: got %h want %h", k + 1, exccode_o, exp_seq[k]);
            end
        end
        clear_inputs();
        wait_idle("b2b");
    endtask

    task automatic test_ades();
        mem_pc_i    = 32'hbfc00400;
        mem_daddr_i = 32'h80000003;
        mem_exc_i   = 7'b1000000;
        mem_valid_i = 1'b1;
        step();
        checks++;
        if (exccode_o !== 5'h05 || badvaddr_o !== 32'h80000003) begin
            errors++;
            $display("FAIL ades: code=%h bad=%h want 05 80000003", exccode_o, badvaddr_o);
        end
        clear_inputs();
        wait_idle("ades");
    endtask

    task automatic test_int_priority();
        status_i    = 32'h0000ff01;
        cause_i     = 32'h00000400;
        mem_exc_i   = 7'b0000100;
        mem_pc_i    = 32'hbfc00500;
        mem_valid_i = 1'b1;
        step();
        checks++;
        if (exccode_o !== 5'h00) begin
            errors++;
            $display("FAIL int_over_ov: got %h want 00", exccode_o);
        end
        clear_inputs();
        wait_idle("int");
        status_i    = 32'h0000ff03;
        cause_i     = 32'h00000400;
        mem_exc_i   = 7'b0000100;
        mem_pc_i    = 32'hbfc00504;
        mem_valid_i = 1'b1;
        step();
        checks++;
        if (exccode_o !== 5'h0c) begin
            errors++;
            $display("FAIL ov_exl_masked: got %h want 0c", exccode_o);
        end
        clear_inputs();
        wait_idle("ov");
    endtask

    task automatic test_eret_wait();
        redirect_ready_i = 1'b0;
        cp0_excaddr_i    = 32'h80000180;
        mem_pc_i         = 32'hbfc00600;
        mem_eret_i       = 1'b1;
        mem_valid_i      = 1'b1;
        step();
        checks++;
        if (exccode_o !== 5'h11) begin
            errors++;
            $display("FAIL eret_code: got %h want 11", exccode_o);
        end
        // Second exception presented while the sequencer is busy.
        mem_eret_i = 1'b0;
        mem_exc_i  = 7'b0000010;
        for (int k = 0; k < 4; k++) begin
            step();
            cp0_excaddr_i = 32'hdeadbeef;
            checks++;
            if (redirect_valid_o !== 1'b1 || redirect_addr_o !== 32'h80000180 || exccode_o !== 5'h10) begin
                errors++;
                $display("FAIL eret_hold_c%0d: rv=%b ra=%h code=%h want 1 80000180 10",
                         k, redirect_valid_o, redirect_addr_o, exccode_o);
            end
            if (k == 3) redirect_ready_i = 1'b1;
        end
        step();
        checks++;
        if (redirect_valid_o !== 1'b0 || flush_o !== 1'b1) begin
            errors++;
            $display("FAIL eret_accept: rv=%b fl=%b want 0 1", redirect_valid_o, flush_o);
        end
        clear_inputs();
        cp0_excaddr_i = 32'hbfc00380;
        wait_idle("eret");
        step();
        checks++;
        if (exccode_o !== 5'h10 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL eret_second_ignored: code=%h busy=%b want 10 0", exccode_o, busy_o);
        end
    endtask

    task automatic test_delay_slot();
        mem_pc_i       = 32'hbfc00700;
        mem_in_delay_i = 1'b1;
        mem_exc_i      = 7'b0001000;
        mem_valid_i    = 1'b1;
        step();
        checks++;
        if (exccode_o !== 5'h08 || in_delay_o !== 1'b1 || epc_pc_o !== 32'hbfc00700) begin
            errors++;
            $display("FAIL sys_delay: code=%h dly=%b epc=%h want 08 1 bfc00700", exccode_o, in_delay_o, epc_pc_o);
        end
        clear_inputs();
        wait_idle("sys");
        mem_pc_i    = 32'hbfc00800;
        mem_daddr_i = 32'h12345678;
        mem_exc_i   = 7'b1000011;
        mem_valid_i = 1'b1;
        step();
        checks++;
        if (exccode_o !== 5'h04 || badvaddr_o !== 32'hbfc00800) begin
            errors++;
            $display("FAIL fetch_adel_prio: code=%h bad=%h want 04 bfc00800", exccode_o, badvaddr_o);
        end
        clear_inputs();
        wait_idle("adel");
    endtask

    task automatic test_reset_mid_redirect();
        redirect_ready_i = 1'b0;
        mem_pc_i         = 32'hbfc00900;
        mem_exc_i        = 7'b0000100;
        mem_valid_i      = 1'b1;
        step();
        clear_inputs();
        step();
        checks++;
        if (redirect_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: rv=%b want 1", redirect_valid_o);
        end
        cpu_rst = 1'b1;
        #1;
        checks++;
        if (exccode_o !== 5'h10 ||
            {epc_pc_o, in_delay_o, badvaddr_o, flush_o, redirect_valid_o, redirect_addr_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: code=%h epc=%h dly=%b bad=%h fl=%b rv=%b ra=%h busy=%b want 10 and all 0",
                     exccode_o, epc_pc_o, in_delay_o, badvaddr_o, flush_o, redirect_valid_o, redirect_addr_o, busy_o);
        end
        step();
        cpu_rst          = 1'b0;
        redirect_ready_i = 1'b1;
        cp0_excaddr_i    = 32'hbfc00380;
        step();
        mem_pc_i    = 32'hbfc00a00;
        mem_exc_i   = 7'b0010000;
        mem_valid_i = 1'b1;
        step();
        checks++;
        if (exccode_o !== 5'h09 || epc_pc_o !== 32'hbfc00a00) begin
            errors++;
            $display("FAIL rstmid_fresh: code=%h epc=%h want 09 bfc00a00", exccode_o, epc_pc_o);
        end
        clear_inputs();
        step();
        checks++;
        if (redirect_valid_o !== 1'b1 || redirect_addr_o !== 32'hbfc00380) begin
            errors++;
            $display("FAIL rstmid_fresh_redir: rv=%b ra=%h want 1 bfc00380", redirect_valid_o, redirect_addr_o);
        end
        wait_idle("rstmid");
    endtask

    initial begin
        test_reset();
        test_ri();
        test_back_to_back();
        test_ades();
        test_int_priority();
        test_eret_wait();
        test_delay_slot();
        test_reset_mid_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/interrupt commit controller between the MEM stage and the CP0 block. It samples per-instruction exception flags and the pending-interrupt condition at MEM and selects one cause by fixed priority. It then drives the one-cycle exception code, EPC and BadVAddr to CP0 and sequences the pipeline flush and fetch redirect until the front end has restarted. It is the single source of `exccode` for CP0; CP0 itself stays combinational on that code.

## Interface
- `DRAIN_CYCLES`, default 2: cycles `flush_o` stays high after the redirect handshake, to drop in-flight IM data (min 1).
- `cpu_clk_50M`  in  1  clock.
- `cpu_rst`  in  1  asynchronous, active-high reset.
- `mem_valid_i`  in  1  MEM stage holds a real instruction.
- `mem_pc_i`  in  32  PC of the MEM instruction.
- `mem_in_delay_i`  in  1  MEM instruction is in a delay slot.
- `mem_exc_i`  in  7  flags:
  - [0] fetch ADEL
  - [1] RI
  - [2] OV
  - [3] SYS
  - [4] BP
  - [5] data ADEL
  - [6] data ADES
- `mem_eret_i`  in  1  MEM instruction is ERET.
- `mem_daddr_i`  in  32  data address of the MEM instruction.
- `status_i`, `cause_i`  in  32 each  CP0 Status/Cause.
- `cp0_excaddr_i`  in  32  handler/EPC target from CP0, combinational on `exccode_o`.
- `redirect_ready_i`  in  1  fetch accepts redirect.
- `exccode_o`  out  5  code to CP0:
  - INT=5'h00, ADEL=5'h04, ADES=5'h05, SYS=5'h08, BP=5'h09, RI=5'h0a, OV=5'h0c
  - ERET=5'h11, NONE=5'h10
- `epc_pc_o`  out  32  PC to CP0.
- `in_delay_o`  out  1  delay-slot flag to CP0.
- `badvaddr_o`  out  32  BadVAddr to CP0.
- `flush_o`  out  1  flush IF..MEM.
- `redirect_valid_o`  out  1  redirect request.
- `redirect_addr_o`  out  32  redirect target.
- `busy_o`  out  1  state != IDLE.

## Operation
- States: IDLE, COMMIT, REDIRECT, DRAIN.
- Interrupt pending `int_p` = `status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8])`.
- Trigger, sampled in IDLE only: `mem_valid_i & (int_p | |mem_exc_i | mem_eret_i)`.
- Priority, highest first:
  - INT
  - fetch ADEL
  - RI
  - OV
  - SYS
  - BP
  - data ADEL
  - data ADES
  - ERET
  - Exactly one code is chosen.
- On trigger, capture the following into registers and go to COMMIT:
  - chosen code
  - `mem_pc_i`
  - `mem_in_delay_i`
  - BadVAddr: `mem_pc_i` for fetch ADEL, `mem_daddr_i` for data ADEL/ADES, unchanged otherwise
- COMMIT (exactly 1 cycle):
  - `exccode_o` = captured code; in all other states it is NONE.
  - `epc_pc_o`, `in_delay_o` and `badvaddr_o` are driven; CP0 updates on the closing edge.
  - Latch `cp0_excaddr_i` into `redirect_addr_o`.
  - Go to REDIRECT.
- REDIRECT:
  - `redirect_valid_o`=1, with `redirect_addr_o` stable.
  - On `redirect_valid_o & redirect_ready_i`, load the drain counter with DRAIN_CYCLES and go to DRAIN.
- DRAIN: decrement the counter each cycle; at 1, go to IDLE.
- `flush_o` = 1 in COMMIT, REDIRECT and DRAIN; otherwise 0.
- Triggers outside IDLE are ignored; the pipeline is being flushed.
- `mem_valid_i`=0 never triggers, even with `int_p`=1.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `exccode_o` goes to NONE.
  - All other outputs go to 0.
  - The counter clears.

## Timing
- Trigger seen in cycle T:
  - T+1: COMMIT, `exccode_o` valid, `flush_o`=1.
  - T+2: `redirect_valid_o`=1.
- With `redirect_ready_i` already high, the handshake completes in T+2.
- `flush_o` falls at T+3+DRAIN_CYCLES.
- The earliest next trigger is sampled at T+3+DRAIN_CYCLES.
- All outputs are registered; no combinational path from inputs to outputs.
- `redirect_valid_o` is held until accepted; the address does not change while waiting.
- Reset asserted mid-REDIRECT drops `redirect_valid_o` immediately.

## Test plan
- RI at `mem_pc_i`=32'hbfc00100, not in a delay slot, `redirect_ready_i`=1:
  - `exccode_o`=5'h0a for one cycle, with `epc_pc_o`=32'hbfc00100 and `in_delay_o`=0.
  - `redirect_addr_o` = `cp0_excaddr_i` value (32'hbfc00380).
  - `flush_o` is high 4 cycles with DRAIN_CYCLES=2.
- Data ADES at `mem_daddr_i`=32'h80000003:
  - `exccode_o`=5'h05.
  - `badvaddr_o`=32'h80000003.
- Interrupt concurrent with OV:
  - Inputs: `status_i`=32'h0000ff01, `cause_i[10]`=1, `mem_exc_i[2]`=1.
  - `exccode_o`=5'h00.
  - With `status_i[1]`=1 instead: `exccode_o`=5'h0c.
- ERET with `redirect_ready_i` low for 3 cycles:
  - `exccode_o`=5'h11 for one cycle.
  - `redirect_valid_o` is held 4 cycles with a constant address.
  - A second exception during the wait is ignored.
- Delay-slot SYS:
  - `in_delay_o`=1.
  - `mem_exc_i`=7'b1000011 also selects fetch ADEL, with `badvaddr_o`=`mem_pc_i`.
- Assert `cpu_rst` during REDIRECT:
  - All outputs are 0 and `exccode_o`=5'h10 in the same cycle.
  - A fresh exception after release completes normally.
